ysyx_22040386_ifu_prefetch: RTL and testbench
=============================================

# ysyx_22040386_ifu_prefetch

Parametrised instruction-fetch stage with a decoupled memory request/response interface and an in-order prefetch queue. It replaces the single-PC, combinational-read fetch. It issues up to DEPTH fetches ahead of decode, holds returned instructions until decode accepts them, and handles branch redirects by flushing the queue and discarding stale in-flight responses. It sits between the instruction memory port and the ID stage, and exposes early register-read addresses as before.

## Interface
- RESET_PC, 64'h0000_0000_8000_0000: first fetch address after reset.
- DEPTH, 4: queue entries, which is also the maximum number of outstanding fetches; power of two, ≥2.
- XLEN, 64: PC width.
- i_IF_clk  in  1  clock; all logic is on the rising edge.
- i_IF_rst  in  1  reset; synchronous, active-high.
- o_IF_req_valid  out  1  fetch request valid.
- i_IF_req_ready  in  1  memory accepts the request this cycle.
- o_IF_req_addr  out  XLEN  fetch address, 4-byte aligned.
- i_IF_rsp_valid  in  1  instruction returned; responses arrive in request order and have no backpressure.
- i_IF_rsp_inst  in  32  returned instruction.
- i_IF_redirect  in  1  branch/jump taken; flush the queue and restart fetch.
- i_IF_redirect_pc  in  XLEN  new fetch PC; bits [1:0] are ignored and treated as 0.
- o_IF_valid  out  1  head entry holds a valid instruction for decode.
- i_IF_ready  in  1  decode accepts the head; low means stall (load-use).
- o_IF_pc  out  XLEN  PC of the head entry.
- o_IF_inst  out  32  instruction of the head entry.
- o_IF_reg_rd_addr1  out  5  o_IF_inst[19:15].
- o_IF_reg_rd_addr2  out  5  o_IF_inst[24:20].

## Operation
- State:
  - fetch_pc register.
  - Circular queue of DEPTH entries {pc, inst, filled}, with alloc, fill and head pointers, each log2(DEPTH)+1 bits so full and empty can be told apart.
  - drop_cnt counter (0..DEPTH).
- Allocate on request:
  - o_IF_req_valid = !i_IF_rst && !i_IF_redirect && (count + drop_cnt < DEPTH).
  - o_IF_req_addr = fetch_pc.
  - On req_valid && req_ready: write pc into the entry at alloc, clear its filled bit, advance alloc, and set fetch_pc += 4 (modulo 2^XLEN, wraps).
- Fill on response:
  - On rsp_valid with drop_cnt > 0, decrement drop_cnt and discard the data.
  - Otherwise write inst into the entry at fill, set filled, and advance fill.
  - A response with no unfilled entry and drop_cnt == 0 is a protocol error; an assertion fires and the response is ignored.
- Pop to decode:
  - o_IF_valid = queue not empty && head.filled.
  - On o_IF_valid && i_IF_ready, advance head.
  - While i_IF_ready is low, the head and all outputs hold.
- Redirect (highest priority, overrides stall, request and pop):
  - fetch_pc <= {i_IF_redirect_pc[XLEN-1:2], 2'b00}.
  - All pointers reset, so the queue is empty.
  - drop_cnt <= drop_cnt + (allocated-but-unfilled entries) − (i_IF_rsp_valid ? 1 : 0).
  - No request is issued in the redirect cycle.
  - o_IF_valid is 0 in the cycle after a redirect.
- Back-to-back redirects accumulate drop_cnt correctly. drop_cnt never exceeds DEPTH, guaranteed by the credit rule.
- Simultaneous events in one cycle: request, response and pop without redirect are all honoured, and count stays consistent.

## Timing
- Reset values:
  - fetch_pc = RESET_PC; queue empty; drop_cnt = 0.
  - o_IF_req_valid = 0, o_IF_valid = 0.
  - o_IF_pc = RESET_PC, o_IF_inst = 32'h0000_0013 (NOP).
- Reset asserted mid-operation discards all state in the same edge, including outstanding responses. The memory is reset together with the IFU.
- First request is in the first cycle after reset deasserts, with address RESET_PC.
- A response in cycle N makes the instruction visible on o_IF_valid/o_IF_inst in cycle N+1 if it is the head.
- With a zero-wait memory (ready=1, response the cycle after acceptance), sustained throughput is 1 instruction/cycle.
- Redirect at edge N: first request to the new PC in cycle N+1; earliest o_IF_valid for it is N+3 with zero-wait memory.
- All outputs are registered or driven from queue state; there is no combinational path from i_IF_ready to o_IF_req_valid.

## Structure
- Package ysyx_22040386_ifu_pkg holds: default RESET_PC, the NOP constant, and the queue entry typedef {pc, inst, filled}.
- Sub-module ysyx_22040386_ifu_queue holds the DEPTH-entry alloc/fill/pop queue with pointers, count and flush. The top level keeps fetch_pc, the credit logic and drop_cnt.

## Test plan
- Reset release with ready=1 and 1-cycle memory: requests to 0x80000000, 0x80000004, …; o_IF_valid first high 2 cycles after deassert; one instruction per cycle thereafter.
- Memory ready low for 10 cycles with decode ready: the queue drains; no more than DEPTH=4 outstanding; o_IF_valid falls after the last entry pops.
- Hold i_IF_ready low for 6 cycles: the queue fills to 4 and o_IF_req_valid drops; o_IF_pc/o_IF_inst hold; issue resumes the cycle after pops restart.
- Redirect to 0x80001002 with 3 fetches in flight: the next request is 0x80001000; the 3 stale responses are discarded (drop_cnt 3→0); the first decode PC is 0x80001000.
- Redirect coinciding with a response and i_IF_ready=0: drop_cnt equals unfilled−1; no stale instruction reaches decode.
- fetch_pc at 0xFFFF_FFFF_FFFF_FFFC: the next request address wraps to 0x0.

Source files
------------

// File: rtl/ysyx_22040386_ifu_pkg.sv
// Shared constants and the prefetch-queue entry type for the IFU.
package ysyx_22040386_ifu_pkg;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    // One slot of the prefetch queue: the fetch PC, the returned instruction
    // and whether the memory response has arrived yet.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        filled;
    } ifu_entry_t;

endpackage

// File: rtl/ysyx_22040386_ifu_queue.sv
// In-order prefetch queue: entries are allocated when a fetch is issued,
// filled when its response returns and popped when decode accepts them.
// Pointers carry one extra bit so a full queue differs from an empty one.
module ysyx_22040386_ifu_queue
    import ysyx_22040386_ifu_pkg::*;
#(
    parameter int               XLEN     = 64,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC),
    localparam int              PTR_W    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_alloc,
    input  logic [XLEN-1:0]  i_alloc_pc,
    input  logic             i_fill,
    input  logic [31:0]      i_fill_inst,
    input  logic             i_pop,
    output logic [PTR_W:0]   o_count,
    output logic [PTR_W:0]   o_unfilled,
    output logic             o_head_valid,
    output logic [XLEN-1:0]  o_head_pc,
    output logic [31:0]      o_head_inst
);

    ifu_entry_t        r_mem [DEPTH];
    logic [PTR_W:0]    r_alloc;
    logic [PTR_W:0]    r_fill;
    logic [PTR_W:0]    r_head;

    logic [PTR_W-1:0]  w_alloc_idx;
    logic [PTR_W-1:0]  w_fill_idx;
    logic [PTR_W-1:0]  w_head_idx;

    assign w_alloc_idx = r_alloc[PTR_W-1:0];
    assign w_fill_idx  = r_fill[PTR_W-1:0];
    assign w_head_idx  = r_head[PTR_W-1:0];

    // Pointer and entry update: reset and flush empty the queue; otherwise
    // allocate, fill and pop may all happen in the same cycle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of its neighbours.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_alloc <= '0;
            r_fill  <= '0;
            r_head  <= '0;
            // NOTE: the entries are reset (not just the pointers) because the
            // head slot drives o_IF_pc/o_IF_inst, which must read RESET_PC/NOP
            // straight out of reset; the queue is small enough for this.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '{pc: 64'(RESET_PC), inst: NOP_INST, filled: 1'b0};
            end
        end else if (i_flush) begin
            r_alloc <= '0;
            r_fill  <= '0;
            r_head  <= '0;
        end else begin
            if (i_alloc) begin
                r_mem[w_alloc_idx].pc     <= 64'(i_alloc_pc);
                r_mem[w_alloc_idx].filled <= 1'b0;
                r_alloc                   <= r_alloc + 1'b1;
            end
            if (i_fill) begin
                r_mem[w_fill_idx].inst   <= i_fill_inst;
                r_mem[w_fill_idx].filled <= 1'b1;
                r_fill                   <= r_fill + 1'b1;
            end
            if (i_pop) begin
                r_head <= r_head + 1'b1;
            end
        end
    end

    assign o_count      = r_alloc - r_head;
    assign o_unfilled   = r_alloc - r_fill;
    assign o_head_valid = (r_head != r_alloc) && r_mem[w_head_idx].filled;
    assign o_head_pc    = XLEN'(r_mem[w_head_idx].pc);
    assign o_head_inst  = r_mem[w_head_idx].inst;

endmodule

// File: rtl/ysyx_22040386_ifu_prefetch.sv
// Instruction-fetch stage with a decoupled memory port and a prefetch queue.
// Keeps the fetch PC, the request credit (queue occupancy plus responses
// still owed to flushed entries) and the count of stale responses to drop.
module ysyx_22040386_ifu_prefetch
    import ysyx_22040386_ifu_pkg::*;
#(
    parameter int               XLEN     = 64,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic             i_IF_clk,
    input  logic             i_IF_rst,
    output logic             o_IF_req_valid,
    input  logic             i_IF_req_ready,
    output logic [XLEN-1:0]  o_IF_req_addr,
    input  logic             i_IF_rsp_valid,
    input  logic [31:0]      i_IF_rsp_inst,
    input  logic             i_IF_redirect,
    input  logic [XLEN-1:0]  i_IF_redirect_pc,
    output logic             o_IF_valid,
    input  logic             i_IF_ready,
    output logic [XLEN-1:0]  o_IF_pc,
    output logic [31:0]      o_IF_inst,
    output logic [4:0]       o_IF_reg_rd_addr1,
    output logic [4:0]       o_IF_reg_rd_addr2
);

    localparam int              PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W+1:0] DEPTH_EXT = (PTR_W + 2)'(DEPTH);

    logic [XLEN-1:0]  r_fetch_pc;
    logic [PTR_W:0]   r_drop_cnt;

    logic [PTR_W:0]   w_count;
    logic [PTR_W:0]   w_unfilled;
    logic [PTR_W+1:0] w_in_use;
    logic             w_req_fire;
    logic             w_drop_rsp;
    logic             w_fill;
    logic             w_pop;
    logic [PTR_W:0]   w_rsp_dec;
    logic             w_unused;

    // Credit counts live queue entries plus responses still owed to flushed
    // entries, so the memory never has more than DEPTH fetches outstanding.
    assign w_in_use       = {1'b0, w_count} + {1'b0, r_drop_cnt};
    assign o_IF_req_valid = !i_IF_rst && !i_IF_redirect && (w_in_use < DEPTH_EXT);
    assign o_IF_req_addr  = r_fetch_pc;
    assign w_req_fire     = o_IF_req_valid && i_IF_req_ready;

    // Stale responses are consumed first; only then do responses fill entries.
    assign w_drop_rsp = i_IF_rsp_valid && (r_drop_cnt != '0);
    assign w_fill     = i_IF_rsp_valid && (r_drop_cnt == '0) && (w_unfilled != '0);
    assign w_pop      = o_IF_valid && i_IF_ready;
    assign w_rsp_dec  = {{PTR_W{1'b0}}, i_IF_rsp_valid};

    // The low two redirect bits are architecturally ignored.
    assign w_unused = ^i_IF_redirect_pc[1:0];

    ysyx_22040386_ifu_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_queue (
        .i_clk        (i_IF_clk),
        .i_rst        (i_IF_rst),
        .i_flush      (i_IF_redirect),
        .i_alloc      (w_req_fire),
        .i_alloc_pc   (r_fetch_pc),
        .i_fill       (w_fill),
        .i_fill_inst  (i_IF_rsp_inst),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_unfilled   (w_unfilled),
        .o_head_valid (o_IF_valid),
        .o_head_pc    (o_IF_pc),
        .o_head_inst  (o_IF_inst)
    );

    // Fetch PC and drop counter: a redirect restarts fetch and turns every
    // allocated-but-unfilled entry into a response that must be discarded.
    always_ff @(posedge i_IF_clk) begin
        if (i_IF_rst) begin
            r_fetch_pc <= RESET_PC;
            r_drop_cnt <= '0;
        end else if (i_IF_redirect) begin
            r_fetch_pc <= {i_IF_redirect_pc[XLEN-1:2], 2'b00};
            r_drop_cnt <= r_drop_cnt + w_unfilled - w_rsp_dec;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            if (w_drop_rsp) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
        end
    end

    assign o_IF_reg_rd_addr1 = o_IF_inst[19:15];
    assign o_IF_reg_rd_addr2 = o_IF_inst[24:20];

    // A response with nothing to fill and nothing to drop breaks the
    // in-order memory protocol.
    a_rsp_has_target: assert property (
        @(posedge i_IF_clk) disable iff (i_IF_rst)
        (i_IF_rsp_valid && (r_drop_cnt == '0)) |-> (w_unfilled != '0)
    );

endmodule

// File: tb/tb_ysyx_22040386_ifu_prefetch.sv
// Scoreboard bench for the prefetch IFU. A memory model answers accepted
// requests in order; the reference model tracks the expected fetch PC, the
// live (unflushed) fetches in program order and the stale responses owed.
module tb_ysyx_22040386_ifu_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_inst = '0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        dec_ready = 1'b0;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic [4:0]  ra1;
    logic [4:0]  ra2;

    always #5 clk = ~clk;

    ysyx_22040386_ifu_prefetch #(
        .XLEN     (64),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .i_IF_clk          (clk),
        .i_IF_rst          (rst),
        .o_IF_req_valid    (req_valid),
        .i_IF_req_ready    (req_ready),
        .o_IF_req_addr     (req_addr),
        .i_IF_rsp_valid    (rsp_valid),
        .i_IF_rsp_inst     (rsp_inst),
        .i_IF_redirect     (redirect),
        .i_IF_redirect_pc  (redirect_pc),
        .o_IF_valid        (if_valid),
        .i_IF_ready        (dec_ready),
        .o_IF_pc           (if_pc),
        .o_IF_inst         (if_inst),
        .o_IF_reg_rd_addr1 (ra1),
        .o_IF_reg_rd_addr2 (ra2)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        int          epoch;
    } mreq_t;

    exp_t        sb[$];       // live fetches in program order, awaiting decode
    mreq_t       mem_q[$];    // requests accepted by memory, not yet answered
    int          epoch = 0;   // bumps on every redirect/reset
    int          live_filled = 0;
    logic [63:0] exp_pc = RESET_PC;
    int          n_checks = 0;
    int          n_err = 0;

    // Instruction memory contents: an address hash.
    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0F0F_1234;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the edge, check and update the
    // model on the falling edge.
    task automatic step(input logic mr, input int rsp_pct, input logic dr,
                        input logic redir, input logic [63:0] rpc, input logic rst_v);
        int   stale;
        logic exp_rv;
        @(posedge clk);
        #1;
        rst         = rst_v;
        req_ready   = mr;
        dec_ready   = dr;
        redirect    = redir;
        redirect_pc = rpc;
        rsp_valid   = !rst_v && (mem_q.size() > 0) && ($urandom_range(99) < rsp_pct);
        if (rsp_valid) rsp_inst = mem_data(mem_q[0].addr);
        else           rsp_inst = $urandom;
        @(negedge clk);
        if (rst_v) begin
            check("req_valid_in_reset", req_valid, 1'b0);
            sb.delete();
            mem_q.delete();
            live_filled = 0;
            exp_pc      = RESET_PC;
            epoch++;
            return;
        end
        stale = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
        exp_rv = !redir && ((sb.size() + stale) < DEPTH);
        check("req_valid", req_valid, exp_rv);
        check("if_valid", if_valid, live_filled > 0);
        if (exp_rv) check("req_addr", req_addr, exp_pc);
        if (rsp_valid) begin
            if (mem_q[0].epoch == epoch) live_filled++;
            void'(mem_q.pop_front());
        end
        if (redir) begin
            sb.delete();
            live_filled = 0;
            epoch++;
            exp_pc = {rpc[63:2], 2'b00};
        end else if (exp_rv && mr) begin
            sb.push_back('{pc: exp_pc, inst: mem_data(exp_pc)});
            mem_q.push_back('{addr: exp_pc, epoch: epoch});
            exp_pc = exp_pc + 64'd4;
        end
    endtask

    task automatic apply_reset();
        step(1'b0, 0, 1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0, '0, 1'b1);
        check("reset_if_valid", if_valid, 1'b0);
        check("reset_if_pc", if_pc, RESET_PC);
        check("reset_if_inst", if_inst, NOP);
    endtask

    task automatic zero_wait(input int n);
        repeat (n) step(1'b1, 100, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        repeat (8) step(1'b0, 100, 1'b1, 1'b0, '0, 1'b0);
    endtask

    // Monitor: whenever decode takes the head, compare it with the oldest
    // live fetch.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && if_valid && dec_ready && !redirect) begin
                if (sb.size() == 0) begin
                    check("pop_without_fetch", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("dec_pc", if_pc, e.pc);
                    check("dec_inst", if_inst, e.inst);
                    check("dec_rs1", ra1, e.inst[19:15]);
                    check("dec_rs2", ra2, e.inst[24:20]);
                    if (live_filled > 0) live_filled--;
                end
            end
        end
    end

    initial begin
        apply_reset();

        // Streaming with a zero-wait memory.
        zero_wait(20);

        // Memory stalls: queue drains and at most DEPTH are outstanding.
        repeat (10) step(1'b0, 100, 1'b1, 1'b0, '0, 1'b0);
        zero_wait(8);

        // Decode stalls: queue fills, requests stop, head holds.
        repeat (6) step(1'b1, 100, 1'b0, 1'b0, '0, 1'b0);
        zero_wait(8);

        // Redirect with three fetches in flight (unaligned target).
        drain();
        repeat (3) step(1'b1, 0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 0, 1'b1, 1'b1, 64'h0000_0000_8000_1002, 1'b0);
        zero_wait(12);

        // Redirect coinciding with a response and a decode stall.
        drain();
        repeat (3) step(1'b1, 0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 100, 1'b0, 1'b1, 64'h0000_0000_8000_2000, 1'b0);
        zero_wait(12);

        // Back-to-back redirects.
        step(1'b1, 0, 1'b1, 1'b1, 64'h0000_0000_8000_3000, 1'b0);
        step(1'b1, 0, 1'b1, 1'b1, 64'h0000_0000_8000_4000, 1'b0);
        zero_wait(10);

        // Fetch PC wrap-around.
        step(1'b1, 100, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        zero_wait(10);

        // Reset in the middle of traffic.
        repeat (3) step(1'b1, 30, 1'b1, 1'b0, '0, 1'b0);
        apply_reset();
        zero_wait(6);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(999) < 3) begin
                apply_reset();
            end else begin
                step($urandom_range(3) != 0, $urandom_range(100), $urandom_range(3) != 0,
                     $urandom_range(99) < 3, {$urandom, $urandom}, 1'b0);
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
